// File: rtl/axi_xdma_st_data_pkg.sv
// axi_xdma_st_data_pkg: mode codes, checker FSM states and config_reg0 bit positions
package axi_xdma_st_data_pkg;
    localparam logic [1:0] COUNTER_NORMAL = 2'b00;
    localparam logic [1:0] COUNTER_DOWN   = 2'b01;
    localparam logic [1:0] COUNTER_STOP   = 2'b10;
    localparam logic [1:0] RANDOM_DATA    = 2'b11;
    typedef enum logic [1:0] {CLEAR = 2'd0, SEED = 2'd1, CHECK = 2'd2} chk_state_e;
    localparam int CFG_MODE      = 0;
    localparam int CFG_AUTO_SEED = 2;
    localparam int CFG_CLEAR     = 3;
    localparam int CFG_BP_EN     = 4;
endpackage

// File: rtl/axis_bp_lfsr.sv
// axis_bp_lfsr: 16-bit Galois LFSR (taps 16,14,13,11) driving TREADY throttling
module axis_bp_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_en,
    output logic [15:0] o_lfsr
);
    logic [15:0] r_lfsr;
    assign o_lfsr = r_lfsr;
    always_ff @(posedge i_clk) begin
        if (!i_rst_n)
            r_lfsr <= SEED;
        else if (i_en)
            r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
    end
endmodule

// File: rtl/axi_xdma_st_data_chk_slave_stream.sv
// axi_xdma_st_data_chk_slave_stream: AXI-Stream sink checking beats against the generator pattern
module axi_xdma_st_data_chk_slave_stream
    import axi_xdma_st_data_pkg::*;
#(
    parameter int          C_S_AXIS_TDATA_WIDTH  = 128,
    parameter int          NUMBER_OF_INPUT_WORDS = 64,
    parameter logic [15:0] BP_LFSR_SEED          = 16'hACE1
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESETN,
    input  logic                              S_AXIS_TVALID,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    output logic                              S_AXIS_TREADY,
    input  logic [31:0]                       config_reg0,
    input  logic [31:0]                       config_reg1,
    input  logic [31:0]                       config_reg2,
    output logic [63:0]                       beat_count,
    output logic [31:0]                       pkt_count,
    output logic [31:0]                       data_err_count,
    output logic [31:0]                       tlast_err_count,
    output logic                              first_err_valid,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   first_err_data,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   first_err_expected,
    output logic [31:0]                       first_err_beat
);
    localparam int          W        = C_S_AXIS_TDATA_WIDTH;
    localparam logic        CHK_LAST = NUMBER_OF_INPUT_WORDS > 0;
    localparam logic [31:0] LAST_IDX = 32'(NUMBER_OF_INPUT_WORDS) - 32'd1;

    chk_state_e   r_state;
    logic         r_tready;
    logic [63:0]  r_beat_count;
    logic [31:0]  r_pkt_count, r_data_err_count, r_tlast_err_count, r_first_err_beat, r_beat_idx;
    logic         r_first_err_valid;
    logic [W-1:0] r_expected, r_first_err_data, r_first_err_expected;

    logic [15:0]  w_lfsr;
    logic [1:0]   w_mode;
    logic         w_accept, w_data_err, w_at_last, w_tlast_err, w_unused;
    logic [W-1:0] w_step, w_base, w_next_exp;
    logic [31:0]  w_idx_next;

    axis_bp_lfsr #(.SEED(BP_LFSR_SEED)) u_bp_lfsr (
        .i_clk   (S_AXIS_ACLK),
        .i_rst_n (S_AXIS_ARESETN),
        .i_en    (1'b1),
        .o_lfsr  (w_lfsr)
    );

    assign w_unused = ^{config_reg0[31:5], w_lfsr[15:1]};
    assign w_mode   = config_reg0[CFG_MODE +: 2];
    assign w_accept = S_AXIS_TVALID & r_tready;
    assign w_step   = W'({config_reg2, config_reg1});
    // While seeding, the received beat replaces the stored expectation as the base
    assign w_base     = (r_state == SEED) ? S_AXIS_TDATA : r_expected;
    assign w_next_exp = (w_mode == COUNTER_NORMAL) ? w_base + w_step :
                        (w_mode == COUNTER_DOWN)   ? w_base - w_step :
                        (w_mode == COUNTER_STOP)   ? w_base : r_expected;
    assign w_data_err = (r_state == CHECK && w_mode != RANDOM_DATA && S_AXIS_TDATA != r_expected)
                        || !(&S_AXIS_TSTRB);
    assign w_at_last   = CHK_LAST && (r_beat_idx == LAST_IDX);
    assign w_tlast_err = CHK_LAST && (S_AXIS_TLAST != w_at_last);
    assign w_idx_next  = (!CHK_LAST || S_AXIS_TLAST || w_at_last) ? 32'd0 : r_beat_idx + 32'd1;

    assign S_AXIS_TREADY      = r_tready;
    assign beat_count         = r_beat_count;
    assign pkt_count          = r_pkt_count;
    assign data_err_count     = r_data_err_count;
    assign tlast_err_count    = r_tlast_err_count;
    assign first_err_valid    = r_first_err_valid;
    assign first_err_data     = r_first_err_data;
    assign first_err_expected = r_first_err_expected;
    assign first_err_beat     = r_first_err_beat;

    always_ff @(posedge S_AXIS_ACLK) begin
        if (!S_AXIS_ARESETN) begin
            r_state              <= CLEAR;
            r_tready             <= 1'b0;
            r_beat_count         <= '0;
            r_pkt_count          <= '0;
            r_data_err_count     <= '0;
            r_tlast_err_count    <= '0;
            r_first_err_valid    <= 1'b0;
            r_first_err_data     <= '0;
            r_first_err_expected <= '0;
            r_first_err_beat     <= '0;
            r_expected           <= W'(1);
            r_beat_idx           <= '0;
        end else begin
            r_tready <= config_reg0[CFG_CLEAR] ? 1'b0 : config_reg0[CFG_BP_EN] ? w_lfsr[0] : 1'b1;
            if (r_state == CLEAR) begin
                r_beat_count         <= '0;
                r_pkt_count          <= '0;
                r_data_err_count     <= '0;
                r_tlast_err_count    <= '0;
                r_first_err_valid    <= 1'b0;
                r_first_err_data     <= '0;
                r_first_err_expected <= '0;
                r_first_err_beat     <= '0;
                r_expected           <= W'(1);
                r_beat_idx           <= '0;
                r_state <= config_reg0[CFG_CLEAR] ? CLEAR : config_reg0[CFG_AUTO_SEED] ? SEED : CHECK;
            end else begin
                if (w_accept) begin
                    r_beat_count <= r_beat_count + 64'd1;
                    r_pkt_count  <= r_pkt_count + {31'd0, S_AXIS_TLAST};
                    r_expected   <= w_next_exp;
                    r_beat_idx   <= w_idx_next;
                    if (w_data_err) begin
                        r_data_err_count <= r_data_err_count + {31'd0, r_data_err_count != '1};
                        if (!r_first_err_valid) begin
                            r_first_err_valid    <= 1'b1;
                            r_first_err_data     <= S_AXIS_TDATA;
                            r_first_err_expected <= r_expected;
                            r_first_err_beat     <= r_beat_count[31:0];
                        end
                    end
                    if (w_tlast_err)
                        r_tlast_err_count <= r_tlast_err_count + {31'd0, r_tlast_err_count != '1};
                    if (r_state == SEED)
                        r_state <= CHECK;
                end
                if (config_reg0[CFG_CLEAR])
                    r_state <= CLEAR;
            end
        end
    end
endmodule

// File: tb/tb_axi_xdma_st_data_chk_slave_stream.sv
// tb_axi_xdma_st_data_chk_slave_stream: scoreboard and vector-table bench for the stream checker
module tb_axi_xdma_st_data_chk_slave_stream;
    logic         clk = 1'b0;
    logic         rstn;
    logic         tvalid, tlast, tready;
    logic [127:0] tdata;
    logic [15:0]  tstrb;
    logic [31:0]  cfg0, cfg1, cfg2;
    logic [63:0]  beat_count;
    logic [31:0]  pkt_count, data_err_count, tlast_err_count, first_err_beat;
    logic         first_err_valid;
    logic [127:0] first_err_data, first_err_expected;

    axi_xdma_st_data_chk_slave_stream dut (
        .S_AXIS_ACLK        (clk),
        .S_AXIS_ARESETN     (rstn),
        .S_AXIS_TVALID      (tvalid),
        .S_AXIS_TDATA       (tdata),
        .S_AXIS_TSTRB       (tstrb),
        .S_AXIS_TLAST       (tlast),
        .S_AXIS_TREADY      (tready),
        .config_reg0        (cfg0),
        .config_reg1        (cfg1),
        .config_reg2        (cfg2),
        .beat_count         (beat_count),
        .pkt_count          (pkt_count),
        .data_err_count     (data_err_count),
        .tlast_err_count    (tlast_err_count),
        .first_err_valid    (first_err_valid),
        .first_err_data     (first_err_data),
        .first_err_expected (first_err_expected),
        .first_err_beat     (first_err_beat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] beats;
        logic [31:0] pkts;
        logic [31:0] derr;
        logic [31:0] terr;
    } exp_t;
    typedef struct {
        logic [127:0] d;
        logic         l;
        logic [15:0]  s;
        int           ed;
        int           et;
    } vec_t;

    exp_t sb[$];
    vec_t tbl[6];
    int   total = 0, passed = 0, waits = 0, bench_beats = 0, bench_pkts = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("beat_count", 128'(beat_count), 128'(e.beats));
            chk("pkt_count", 128'(pkt_count), 128'(e.pkts));
            chk("data_err_count", 128'(data_err_count), 128'(e.derr));
            chk("tlast_err_count", 128'(tlast_err_count), 128'(e.terr));
        end
    end

    task automatic send(input logic [127:0] d, input logic l, input logic [15:0] s, input int ed, input int et);
        int n = 0;
        tvalid = 1'b1; tdata = d; tlast = l; tstrb = s;
        while (!tready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        waits += n;
        if (!tready) begin
            chk("tready_timeout", 128'(tready), 128'(1));
        end else begin
            @(posedge clk); #1;
            bench_beats++;
            if (l) bench_pkts++;
            sb.push_back('{64'(bench_beats), 32'(bench_pkts), 32'(ed), 32'(et)});
        end
        tvalid = 1'b0;
    endtask

    task automatic do_clear(input logic [31:0] cfg);
        cfg0 = cfg | 32'h8;
        repeat (3) begin @(posedge clk); #1; end
        chk("tready_in_clear", 128'(tready), 128'(0));
        chk("beat_in_clear", 128'(beat_count), 128'(0));
        cfg0 = cfg;
        repeat (2) @(posedge clk);
        #1;
        bench_beats = 0; bench_pkts = 0; waits = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [127:0] d;
        rstn = 1'b0; tvalid = 1'b0; tdata = '0; tlast = 1'b0; tstrb = '1;
        cfg0 = 32'h8; cfg1 = 32'd1; cfg2 = 32'd0;
        tbl[0] = '{128'd1,     1'b0, 16'hFFFF, 0, 0};
        tbl[1] = '{128'd2,     1'b0, 16'hFFFF, 0, 0};
        tbl[2] = '{128'hBAD,   1'b0, 16'hFFFF, 1, 0};
        tbl[3] = '{128'd4,     1'b0, 16'h7FFF, 2, 0};
        tbl[4] = '{128'd5,     1'b1, 16'hFFFF, 2, 1};
        tbl[5] = '{128'd6,     1'b0, 16'hFFFF, 2, 1};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tready", 128'(tready), 128'(0));
        chk("rst_beat", 128'(beat_count), 128'(0));
        chk("rst_derr", 128'(data_err_count), 128'(0));
        chk("rst_first_valid", 128'(first_err_valid), 128'(0));
        chk("rst_first_data", first_err_data, 128'(0));
        rstn = 1'b1;

        do_clear(32'h0);
        for (int i = 1; i <= 64; i++) send(128'(i), i == 64, 16'hFFFF, 0, 0);
        chk("up_no_stall", 128'(waits), 128'(0));

        do_clear(32'h0);
        for (int i = 1; i <= 64; i++) send(i == 10 ? 128'hDEAD : 128'(i), i == 64, 16'hFFFF, i >= 10 ? 1 : 0, 0);
        chk("fe_valid", 128'(first_err_valid), 128'(1));
        chk("fe_beat", 128'(first_err_beat), 128'(9));
        chk("fe_expected", first_err_expected, 128'(10));
        chk("fe_data", first_err_data, 128'hDEAD);

        cfg1 = 32'd0; cfg2 = 32'd1;
        do_clear(32'h5);
        d = 128'hFFFF_FFFF_0000_0000;
        for (int i = 0; i < 10; i++) begin
            send(d, 1'b0, 16'hFFFF, 0, 0);
            d = d - 128'h1_0000_0000;
        end
        chk("down_seed_fe_valid", 128'(first_err_valid), 128'(0));

        cfg1 = 32'd1; cfg2 = 32'd0;
        do_clear(32'h0);
        for (int i = 1; i <= 32; i++) send(128'(i), i == 32, 16'hFFFF, 0, i == 32 ? 1 : 0);
        for (int i = 33; i <= 96; i++) send(128'(i), i == 96, 16'hFFFF, 0, 1);

        do_clear(32'h13);
        for (int i = 0; i < 1000; i++)
            send({$urandom, $urandom, $urandom, $urandom}, i % 64 == 63, 16'hFFFF, 0, 0);
        chk("bp_stalls_seen", 128'(waits > 0), 128'(1));

        do_clear(32'h0);
        foreach (tbl[k]) send(tbl[k].d, tbl[k].l, tbl[k].s, tbl[k].ed, tbl[k].et);
        chk("tbl_fe_beat", 128'(first_err_beat), 128'(2));
        chk("tbl_fe_expected", first_err_expected, 128'(3));
        chk("tbl_fe_data", first_err_data, 128'hBAD);
        cfg0 = 32'h8;
        send(128'd7, 1'b0, 16'hFFFF, 2, 1);
        repeat (2) @(posedge clk);
        #1;
        chk("midclr_tready", 128'(tready), 128'(0));
        chk("midclr_beat", 128'(beat_count), 128'(0));
        chk("midclr_derr", 128'(data_err_count), 128'(0));
        chk("midclr_terr", 128'(tlast_err_count), 128'(0));
        chk("midclr_fe_valid", 128'(first_err_valid), 128'(0));
        cfg0 = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        bench_beats = 0; bench_pkts = 0;
        for (int i = 1; i <= 64; i++) send(128'(i), i == 64, 16'hFFFF, 0, 0);

        repeat (3) @(posedge clk);
        #1;
        chk("sb_drained", 128'(sb.size()), 128'(0));
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
